// File: rtl/junction_phase_sequencer.sv
// -----------------------------------------------------------------------------
// junction_phase_sequencer
// Tick-timed phase scheduler for a highway / country-road junction. Arbitrates
// between the country-road car sensor, a latched pedestrian button and an
// emergency pre-empt, and drives both light heads plus the WALK lamp. Dwell
// times are counted in tick strobes, not raw clocks.
//
// Ports:
//   clk          system clock, rising edge
//   clear        synchronous active-high reset
//   tick         one-cycle timing strobe; dwell counter advances only on tick
//   car_req      country-road vehicle present (level)
//   ped_req      pedestrian button (pulse or level), latched internally
//   emerg        emergency pre-empt (level), forces highway priority
//   hw_light     highway head        RED=00 YELLOW=01 GREEN=10
//   cr_light     country-road head   same encoding
//   walk         pedestrian WALK lamp across the highway
//   ped_pending  pedestrian request latched, not yet served
//   phase        current state code (debug / scoreboard)
// -----------------------------------------------------------------------------

// Checks that the two heads are never simultaneously non-RED.
module junction_phase_sequencer_checker (
    input logic       clk,
    input logic       clear,
    input logic [1:0] hw_light,
    input logic [1:0] cr_light
);
    heads_exclusive: assert property (@(posedge clk) disable iff (clear)
        !((hw_light != 2'b00) && (cr_light != 2'b00)));
endmodule

module junction_phase_sequencer #(
    parameter int MIN_GREEN    = 4,
    parameter int MAX_CR_GREEN = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       tick,
    input  logic       car_req,
    input  logic       ped_req,
    input  logic       emerg,
    output logic [1:0] hw_light,
    output logic [1:0] cr_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        HW_GREEN  = 3'd0,
        HW_YELLOW = 3'd1,
        ALL_RED1  = 3'd2,
        CR_GREEN  = 3'd3,
        CR_YELLOW = 3'd4,
        ALL_RED2  = 3'd5
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // Last counter value of each dwell: Expired(N) is cnt == N-1 on a tick.
    localparam logic [CNT_W-1:0] MIN_G_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_CR_LAST = CNT_W'(MAX_CR_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ARED_LAST   = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONES    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_pending_q, ped_pending_d;
    logic             walk_q, walk_d;
    logic [1:0]       hw_light_q, hw_light_d;
    logic [1:0]       cr_light_q, cr_light_d;

    // Next-state, dwell counter, pedestrian latch and lamp decode of next state.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ped_pending_d = ped_pending_q | ped_req;
        walk_d        = 1'b0;
        hw_light_d    = LAMP_RED;
        cr_light_d    = LAMP_RED;

        case (state_q)
            HW_GREEN: begin
                if (tick && (cnt_q >= MIN_G_LAST) && (car_req || ped_pending_q) && !emerg) begin
                    state_d = HW_YELLOW;
                end else begin
                    state_d = HW_GREEN;
                end
            end
            HW_YELLOW: begin
                if (tick && (cnt_q == YEL_LAST)) begin
                    state_d = ALL_RED1;
                end else begin
                    state_d = HW_YELLOW;
                end
            end
            ALL_RED1: begin
                // Emergency arriving during clearance diverts straight back to the highway.
                if (tick && (cnt_q == ARED_LAST)) begin
                    state_d = emerg ? HW_GREEN : CR_GREEN;
                end else begin
                    state_d = ALL_RED1;
                end
            end
            CR_GREEN: begin
                // Emergency leaves immediately, ignoring tick and minimum green.
                if (emerg) begin
                    state_d = CR_YELLOW;
                end else if (tick && (((cnt_q >= MIN_G_LAST) && !car_req) || (cnt_q == MAX_CR_LAST))) begin
                    state_d = CR_YELLOW;
                end else begin
                    state_d = CR_GREEN;
                end
            end
            CR_YELLOW: begin
                if (tick && (cnt_q == YEL_LAST)) begin
                    state_d = ALL_RED2;
                end else begin
                    state_d = CR_YELLOW;
                end
            end
            ALL_RED2: begin
                if (tick && (cnt_q == ARED_LAST)) begin
                    state_d = HW_GREEN;
                end else begin
                    state_d = ALL_RED2;
                end
            end
            default: begin
                state_d = HW_GREEN;
            end
        endcase

        // Counter restarts on every state entry, otherwise saturates on ticks.
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else if (tick && (cnt_q != CNT_ONES)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        // A press on the entry clock is served by this crossing, so it lights WALK too.
        if ((state_d == CR_GREEN) && (state_q != CR_GREEN)) begin
            ped_pending_d = 1'b0;
            walk_d        = ped_pending_q | ped_req;
        end else if (state_d == CR_GREEN) begin
            walk_d = walk_q;
        end else begin
            walk_d = 1'b0;
        end

        case (state_d)
            HW_GREEN:  hw_light_d = LAMP_GREEN;
            HW_YELLOW: hw_light_d = LAMP_YELLOW;
            CR_GREEN:  cr_light_d = LAMP_GREEN;
            CR_YELLOW: cr_light_d = LAMP_YELLOW;
            default: begin
                hw_light_d = LAMP_RED;
                cr_light_d = LAMP_RED;
            end
        endcase
    end

    // State, counter and registered Moore outputs with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= HW_GREEN;
            cnt_q         <= CNT_ZERO;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
            hw_light_q    <= LAMP_GREEN;
            cr_light_q    <= LAMP_RED;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
            hw_light_q    <= hw_light_d;
            cr_light_q    <= cr_light_d;
        end
    end

    assign hw_light    = hw_light_q;
    assign cr_light    = cr_light_q;
    assign walk        = walk_q;
    assign ped_pending = ped_pending_q;
    assign phase       = state_q;

    junction_phase_sequencer_checker u_checker (
        .clk      (clk),
        .clear    (clear),
        .hw_light (hw_light_q),
        .cr_light (cr_light_q)
    );
endmodule

// File: tb/tb_junction_phase_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for junction_phase_sequencer. A behavioural junction model computes
// the expected phase/lamp/pedestrian word for every clock; the word is queued
// when the inputs are driven and popped and compared after the clock edge.
// Directed checks confirm dwell lengths and the pre-empt / reset scenarios.
// -----------------------------------------------------------------------------
module tb_junction_phase_sequencer;
    localparam int MIN_GREEN    = 4;
    localparam int MAX_CR_GREEN = 8;
    localparam int YELLOW_TICKS = 3;
    localparam int ALLRED_TICKS = 2;
    localparam int CNT_W        = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       tick = 1'b1;
    logic       car_req = 1'b0;
    logic       ped_req = 1'b0;
    logic       emerg = 1'b0;
    logic [1:0] hw_light;
    logic [1:0] cr_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    junction_phase_sequencer #(
        .MIN_GREEN    (MIN_GREEN),
        .MAX_CR_GREEN (MAX_CR_GREEN),
        .YELLOW_TICKS (YELLOW_TICKS),
        .ALLRED_TICKS (ALLRED_TICKS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .tick        (tick),
        .car_req     (car_req),
        .ped_req     (ped_req),
        .emerg       (emerg),
        .hw_light    (hw_light),
        .cr_light    (cr_light),
        .walk        (walk),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected word: {phase[2:0], hw[1:0], cr[1:0], walk, ped_pending}
    logic [8:0] exp_q[$];

    // Model state
    int   m_state = 0;
    int   m_cnt   = 0;
    logic m_ped   = 1'b0;
    logic m_walk  = 1'b0;

    // Observed dwell lengths (in clocks) of the most recently completed visit to each phase
    int dur[8];
    int last_phase = 7;
    int run_len    = 0;
    int walk_cnt   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_word();
        logic [1:0] hw;
        logic [1:0] cr;
        hw = (m_state == 0) ? 2'b10 : (m_state == 1) ? 2'b01 : 2'b00;
        cr = (m_state == 3) ? 2'b10 : (m_state == 4) ? 2'b01 : 2'b00;
        return {3'(m_state), hw, cr, m_walk, m_ped};
    endfunction

    // Advance the junction model by one clock using the currently driven inputs.
    task automatic model_step();
        int nxt;
        if (clear) begin
            m_state = 0;
            m_cnt   = 0;
            m_ped   = 1'b0;
            m_walk  = 1'b0;
        end else begin
            nxt = m_state;
            case (m_state)
                0: if (tick && m_cnt >= MIN_GREEN - 1 && (car_req || m_ped) && !emerg) nxt = 1;
                1: if (tick && m_cnt == YELLOW_TICKS - 1) nxt = 2;
                2: if (tick && m_cnt == ALLRED_TICKS - 1) nxt = emerg ? 0 : 3;
                3: begin
                    if (emerg) nxt = 4;
                    else if (tick && ((m_cnt >= MIN_GREEN - 1 && !car_req) || m_cnt == MAX_CR_GREEN - 1)) nxt = 4;
                end
                4: if (tick && m_cnt == YELLOW_TICKS - 1) nxt = 5;
                5: if (tick && m_cnt == ALLRED_TICKS - 1) nxt = 0;
                default: nxt = 0;
            endcase
            if (nxt == 3 && m_state != 3) begin
                m_walk = m_ped || ped_req;
                m_ped  = 1'b0;
            end else begin
                if (nxt != 3) m_walk = 1'b0;
                m_ped = m_ped || ped_req;
            end
            if (nxt != m_state) m_cnt = 0;
            else if (tick && m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            m_state = nxt;
        end
    endtask

    // One clock: queue the expectation, clock the DUT, pop and compare.
    task automatic cyc();
        logic [8:0] e;
        model_step();
        exp_q.push_back(model_word());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("cycle_word", {phase, hw_light, cr_light, walk, ped_pending}, e);
        if (int'(phase) == last_phase) begin
            run_len++;
        end else begin
            dur[last_phase] = run_len;
            last_phase = int'(phase);
            run_len = 1;
        end
        if (walk) walk_cnt++;
    endtask

    task automatic run_until(input int target);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            cyc();
            if (int'(phase) == target) hit = 1'b1;
        end
        if (!hit) check_val("wait_timeout", phase, target);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) dur[i] = 0;

        // Reset
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check_val("rst_phase", phase, 0);
        check_val("rst_hw", hw_light, 2'b10);
        check_val("rst_cr", cr_light, 2'b00);
        check_val("rst_ped", ped_pending, 0);

        // Basic car cycle with max-out of country-road green
        car_req = 1'b1;
        run_until(5);
        run_until(0);
        check_val("dur_hw_green", dur[0], 4);
        check_val("dur_hw_yellow", dur[1], 3);
        check_val("dur_all_red1", dur[2], 2);
        check_val("dur_cr_green_max", dur[3], 8);
        check_val("dur_cr_yellow", dur[4], 3);
        check_val("dur_all_red2", dur[5], 2);

        // Idle
        car_req = 1'b0;
        repeat (50) cyc();
        check_val("idle_phase", phase, 0);

        // Short car: minimum green
        car_req = 1'b1;
        run_until(3);
        car_req = 1'b0;
        run_until(4);
        check_val("dur_cr_green_min", dur[3], 4);
        run_until(0);

        // Pedestrian pulse
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        check_val("ped_latched", ped_pending, 1);
        walk_cnt = 0;
        run_until(3);
        check_val("ped_cleared_on_entry", ped_pending, 0);
        run_until(4);
        check_val("walk_clocks", walk_cnt, 4);
        check_val("walk_off_on_exit", walk, 0);
        run_until(0);

        // Emergency at CR_GREEN cnt=1
        car_req = 1'b1;
        run_until(3);
        cyc();
        emerg = 1'b1;
        cyc();
        check_val("emerg_cr_exit", phase, 4);
        run_until(0);
        repeat (20) cyc();
        check_val("emerg_hold_hw", phase, 0);
        emerg = 1'b0;

        // tick gating mid HW_YELLOW
        run_until(1);
        cyc();
        tick = 1'b0;
        repeat (10) cyc();
        check_val("tick_freeze", phase, 1);
        tick = 1'b1;
        run_until(2);
        check_val("dur_hw_yellow_gated", dur[1], 13);

        // Emergency at end of ALL_RED1 diverts to HW_GREEN
        run_until(0);
        run_until(2);
        emerg = 1'b1;
        cyc();
        cyc();
        check_val("allred1_divert", phase, 0);
        emerg = 1'b0;

        // Clear mid CR_GREEN with walk lit
        ped_req = 1'b1;
        cyc();
        ped_req = 1'b0;
        run_until(3);
        check_val("walk_lit", walk, 1);
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        check_val("clr_phase", phase, 0);
        check_val("clr_ped", ped_pending, 0);
        check_val("clr_walk", walk, 0);
        car_req = 1'b0;
        repeat (5) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
